pixel_write_queue: RTL and testbench

PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

---
 rtl/pixel_write_queue_pkg.sv | 30 +++
 rtl/pixel_write_queue_fifo.sv | 68 ++++++
 rtl/pixel_write_queue.sv | 133 +++++++++++++
 tb/tb_pixel_write_queue.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_queue_pkg.sv
// Shared video definitions: screen geometry, colour depths, queued pixel entry
// layout and the pixel-queue control states.
package pixel_write_queue_pkg;

  localparam int VID_SCREEN_W   = 160;
  localparam int VID_SCREEN_H   = 120;
  localparam int VID_IN_CBITS   = 8;
  localparam int VID_OUT_CBITS  = 3;

  typedef struct packed {
    logic [7:0]               x;
    logic [6:0]               y;
    logic [VID_OUT_CBITS-1:0] r;
    logic [VID_OUT_CBITS-1:0] g;
    logic [VID_OUT_CBITS-1:0] b;
  } pixel_entry_t;

  localparam int PIXEL_ENTRY_W = $bits(pixel_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } ctrl_state_t;

  function automatic logic [3*VID_OUT_CBITS-1:0] entry_colour(pixel_entry_t e);
    return {e.r, e.g, e.b};
  endfunction

endpackage

// File: rtl/pixel_write_queue_fifo.sv
// Pixel storage ring: DEPTH entries (power of two), head is read combinationally,
// pointers wrap naturally because the pointer width is log2(DEPTH).
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write into a full ring is only legal when the head leaves the same cycle.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/pixel_write_queue.sv
// Pixel write queue between the map/tile drawers and the VGA adapter: clips,
// packs colour to 3:3:3, buffers in a FIFO and replays one pixel per ready cycle.
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = VID_SCREEN_W,
  parameter int SCREEN_H = VID_SCREEN_H
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [7:0]             in_x,
  input  logic [7:0]             in_y,
  input  logic [23:0]            in_rgb,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   clear_flags,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [8:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   full,
  output logic                   empty,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   clipped,
  output logic [1:0]             dbg_state
);

  // Handshake: a pixel is offered when in_valid resolves to 1; it is taken at the
  // edge if in range and there is room (or the head leaves that same edge). A
  // pop happens at any edge with out_ready high and a non-empty queue, and the
  // popped pixel is presented with vga_plot high for exactly the next cycle.

  ctrl_state_t  state_q, state_d;
  pixel_entry_t wr_entry, rd_entry;
  logic         fifo_full, fifo_empty;
  logic         valid_hi, in_range, gate, pop, push, clip_ev, ovf_ev;
  logic [7:0]   vga_x_q;
  logic [6:0]   vga_y_q;
  logic [8:0]   vga_colour_q;
  logic         vga_plot_q, overflow_q, clipped_q;
  logic         overflow_d, clipped_d;
  logic         unused_rgb_bits;

  assign valid_hi = (in_valid === 1'b1);
  assign in_range = (32'(in_x) < 32'(SCREEN_W)) && (32'(in_y) < 32'(SCREEN_H));
  // The flush edge and the FLUSH cycle after it both ignore traffic.
  assign gate     = flush | (state_q == ST_FLUSH);
  assign pop      = ~gate & out_ready & ~fifo_empty;
  assign push     = ~gate & valid_hi & in_range & (~fifo_full | pop);
  assign clip_ev  = ~gate & valid_hi & ~in_range;
  assign ovf_ev   = ~gate & valid_hi & in_range & fifo_full & ~pop;

  assign wr_entry = {in_x, in_y[6:0], in_rgb[23:21], in_rgb[15:13], in_rgb[7:5]};
  assign unused_rgb_bits = ^{in_rgb[20:16], in_rgb[12:8], in_rgb[4:0]};

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIXEL_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (flush),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (push) state_d = ST_STREAM;
        // Nothing left next cycle: no entry remains and no plot gets scheduled.
        ST_STREAM: if (fifo_empty && !push && !pop) state_d = ST_IDLE;
        ST_FLUSH:  state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    clipped_d  = clipped_q;
    if (!gate) begin
      overflow_d = ovf_ev  | (overflow_q & ~clear_flags);
      clipped_d  = clip_ev | (clipped_q  & ~clear_flags);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      overflow_q   <= 1'b0;
      clipped_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      clipped_q  <= clipped_d;
      vga_plot_q <= pop;
      if (pop) begin
        vga_x_q      <= rd_entry.x;
        vga_y_q      <= rd_entry.y;
        vga_colour_q <= entry_colour(rd_entry);
      end
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign idle       = fifo_empty & ~vga_plot_q;
  assign overflow   = overflow_q;
  assign clipped    = clipped_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Bench for pixel_write_queue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the pixel queue rules.
module tb_pixel_write_queue;

  localparam int DEPTH = 8;

  logic        clk, resetn;
  logic        in_valid;
  logic [7:0]  in_x, in_y;
  logic [23:0] in_rgb;
  logic        out_ready, flush, clear_flags;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot, full, empty, idle, overflow, clipped;
  logic [3:0]  level;
  logic [1:0]  dbg_state;

  pixel_write_queue #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_rgb(in_rgb), .out_ready(out_ready), .flush(flush), .clear_flags(clear_flags),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .full(full), .empty(empty), .idle(idle), .level(level), .overflow(overflow),
    .clipped(clipped), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run, tests_failed, plot_count;

  // reference model: expected queue contents plus registered output state
  logic [23:0] exp_q[$];
  logic        m_plot, m_ovf, m_clip, m_flush_st;
  logic [7:0]  m_x;
  logic [6:0]  m_y;
  logic [8:0]  m_col;

  function automatic logic [23:0] pack(input logic [7:0] x, input logic [7:0] y,
                                       input logic [23:0] rgb);
    return {x, y[6:0], rgb[23:21], rgb[15:13], rgb[7:5]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_plot = 0; m_ovf = 0; m_clip = 0; m_flush_st = 0;
    m_x = 0; m_y = 0; m_col = 0;
  endtask

  // driver tasks
  task automatic drive_idle();
    in_valid = 0; in_x = 0; in_y = 0; in_rgb = 0; flush = 0; clear_flags = 0;
  endtask

  task automatic drive_px(input logic [7:0] x, input logic [7:0] y, input logic [23:0] rgb);
    in_valid = 1; in_x = x; in_y = y; in_rgb = rgb;
  endtask

  // one clock: advance the model on the edge using the applied inputs
  task automatic step();
    logic vh, gate, inr, pop, push_ok;
    logic [23:0] head;
    @(posedge clk);
    vh      = (in_valid === 1'b1);
    gate    = flush || m_flush_st;
    inr     = (in_x < 160) && (in_y < 120);
    pop     = !gate && out_ready && (exp_q.size() > 0);
    push_ok = !gate && vh && inr && ((exp_q.size() < DEPTH) || pop);
    if (!gate) begin
      m_ovf  = (vh && inr && exp_q.size() == DEPTH && !pop) || (m_ovf && !clear_flags);
      m_clip = (vh && !inr) || (m_clip && !clear_flags);
    end
    m_plot = pop;
    if (pop) begin
      head  = exp_q.pop_front();
      m_x   = head[23:16];
      m_y   = head[15:9];
      m_col = head[8:0];
    end
    if (flush) exp_q.delete();
    if (push_ok) exp_q.push_back(pack(in_x, in_y, in_rgb));
    m_flush_st = flush;
    #1;
    if (vga_plot === 1'b1) plot_count++;
  endtask

  task automatic do_reset();
    resetn = 0; out_ready = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({level, empty, full, idle, vga_plot} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_status: got lvl/e/f/i/p=%b expected 0000_1_0_1_0",
               {level, empty, full, idle, vga_plot});
    end
    tests_run++;
    if ({vga_x, vga_y, vga_colour, overflow, clipped} !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", {vga_x, vga_y, vga_colour, overflow, clipped});
    end
  endtask

  task automatic test_single();
    out_ready = 1;
    in_valid = 1'bz; in_x = 8'd1; in_y = 8'd1; in_rgb = 24'h123456;
    step();
    tests_run++;
    if (level !== 4'd0) begin
      tests_failed++; $display("FAIL z_valid_ignored: level got %0d expected 0", level);
    end
    drive_px(8'd10, 8'd20, 24'hFF8040);
    step();  // edge k: pushed
    drive_idle();
    tests_run++;
    if ({vga_plot, level} !== {1'b0, 4'd1}) begin
      tests_failed++; $display("FAIL single_edge_k: plot/level got %b expected 0_0001", {vga_plot, level});
    end
    step();  // edge k+1: popped
    tests_run++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd10, 7'd20, 9'b111_100_010}) begin
      tests_failed++;
      $display("FAIL single_plot: got plot=%b x=%0d y=%0d col=%b expected 1 10 20 111100010",
               vga_plot, vga_x, vga_y, vga_colour);
    end
    step();
    tests_run++;
    if ({vga_plot, idle, vga_x} !== {1'b0, 1'b1, 8'd10}) begin
      tests_failed++; $display("FAIL single_after: plot/idle/x got %b expected 0_1_00001010", {vga_plot, idle, vga_x});
    end
  endtask

  task automatic test_overflow();
    logic [23:0] sent[9];
    int idx;
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      drive_px(8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)), 24'($urandom));
      sent[i] = pack(in_x, in_y, in_rgb);
      step();
    end
    drive_idle();
    step();
    tests_run++;
    if ({full, level, overflow, vga_plot} !== {1'b1, 4'd8, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL overflow_full: full/level/ovf/plot got %b expected 1_1000_1_0", {full, level, overflow, vga_plot});
    end
    out_ready = 1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (vga_plot === 1'b1) begin
        if (idx < 8) begin
          tests_run++;
          if ({vga_x, vga_y, vga_colour} !== sent[idx]) begin
            tests_failed++;
            $display("FAIL overflow_order[%0d]: got %h expected %h", idx, {vga_x, vga_y, vga_colour}, sent[idx]);
          end
        end
        idx++;
      end
    end
    tests_run++;
    if (idx !== 8) begin
      tests_failed++; $display("FAIL overflow_plot_count: got %0d expected 8", idx);
    end
    clear_flags = 1;
    step();
    clear_flags = 0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++; $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_clip();
    int pc0;
    out_ready = 1;
    pc0 = plot_count;
    drive_px(8'd160, 8'd0, 24'($urandom));
    step();
    drive_px(8'd0, 8'd120, 24'($urandom));
    step();
    drive_idle();
    step();
    step();
    tests_run++;
    if ({clipped, level, vga_plot} !== {1'b1, 4'd0, 1'b0} || plot_count !== pc0) begin
      tests_failed++;
      $display("FAIL clip_discard: clip/level/plot got %b plots %0d expected 1_0000_0 plots %0d",
               {clipped, level, vga_plot}, plot_count - pc0, 0);
    end
    clear_flags = 1;
    step();
    clear_flags = 0;
    tests_run++;
    if (clipped !== 1'b0) begin
      tests_failed++; $display("FAIL clip_clear: got %b expected 0", clipped);
    end
    out_ready = 0;
    drive_px(8'd159, 8'd119, 24'hFFFFFF);
    step();
    drive_idle();
    tests_run++;
    if ({level, clipped} !== {4'd1, 1'b0}) begin
      tests_failed++; $display("FAIL clip_edge_accept: level/clip got %b expected 0001_0", {level, clipped});
    end
    out_ready = 1;
    step();
    step();
    tests_run++;
    if ({vga_x, vga_y, vga_colour} !== {8'd159, 7'd119, 9'h1FF}) begin
      tests_failed++; $display("FAIL clip_edge_plot: got %h expected %h", {vga_x, vga_y, vga_colour}, {8'd159, 7'd119, 9'h1FF});
    end
  endtask

  task automatic test_full_push_pop();
    int pc0;
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_px(8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)), 24'($urandom));
      step();
    end
    drive_px(8'd7, 8'd9, 24'h00FF00);
    out_ready = 1;
    pc0 = plot_count;
    step();
    drive_idle();
    tests_run++;
    if ({level, full, overflow} !== {4'd8, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL full_push_pop: level/full/ovf got %b expected 1000_1_0", {level, full, overflow});
    end
    for (int c = 0; c < 12; c++) step();
    tests_run++;
    if (plot_count - pc0 !== 9 || {vga_x, vga_y, vga_colour} !== {8'd7, 7'd9, 9'b000_111_000}) begin
      tests_failed++;
      $display("FAIL full_drain: plots %0d last %h expected 9 %h", plot_count - pc0,
               {vga_x, vga_y, vga_colour}, {8'd7, 7'd9, 9'b000_111_000});
    end
  endtask

  task automatic test_flush();
    int pc0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive_px(8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)), 24'($urandom));
      step();
    end
    drive_idle();
    tests_run++;
    if (level !== 4'd5) begin
      tests_failed++; $display("FAIL flush_setup: level got %0d expected 5", level);
    end
    flush = 1;
    out_ready = 1;
    pc0 = plot_count;
    step();
    flush = 0;
    tests_run++;
    if ({empty, idle, level} !== {1'b1, 1'b1, 4'd0}) begin
      tests_failed++; $display("FAIL flush_empty: empty/idle/level got %b expected 1_1_0000", {empty, idle, level});
    end
    for (int c = 0; c < 10; c++) step();
    tests_run++;
    if (plot_count !== pc0) begin
      tests_failed++; $display("FAIL flush_no_plot: got %0d plots expected 0", plot_count - pc0);
    end
  endtask

  task automatic test_reset_mid();
    int pc0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive_px(8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)), 24'($urandom));
      step();
    end
    drive_idle();
    out_ready = 1;
    step();  // streaming: plot high, level 4
    tests_run++;
    if ({vga_plot, level} !== {1'b1, 4'd4}) begin
      tests_failed++; $display("FAIL midreset_setup: plot/level got %b expected 1_0100", {vga_plot, level});
    end
    #2 resetn = 0;
    #1;
    model_reset();
    tests_run++;
    if ({level, empty, full, idle, vga_plot, vga_x, vga_y, vga_colour, overflow, clipped}
        !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0}) begin
      tests_failed++;
      $display("FAIL midreset_async: got %h expected %h",
               {level, empty, full, idle, vga_plot, vga_x, vga_y, vga_colour, overflow, clipped},
               {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 26'd0});
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    pc0 = plot_count;
    for (int c = 0; c < 10; c++) step();
    tests_run++;
    if (plot_count !== pc0 || level !== 4'd0) begin
      tests_failed++; $display("FAIL midreset_release: plots %0d level %0d expected 0 0", plot_count - pc0, level);
    end
  endtask

  task automatic test_random();
    int ready_pct;
    for (int c = 0; c < 600; c++) begin
      ready_pct = ((c / 100) % 3 == 0) ? 20 : (((c / 100) % 3 == 1) ? 60 : 95);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_x        = 8'($urandom_range(0, 175));
      in_y        = 8'($urandom_range(0, 130));
      in_rgb      = 24'($urandom);
      out_ready   = ($urandom_range(0, 99) < ready_pct);
      flush       = ($urandom_range(0, 60) == 0);
      clear_flags = ($urandom_range(0, 25) == 0);
      step();
      tests_run++;
      if ({vga_plot, vga_x, vga_y, vga_colour} !== {m_plot, m_x, m_y, m_col}) begin
        tests_failed++;
        $display("FAIL rand_out[%0d]: got %h expected %h", c, {vga_plot, vga_x, vga_y, vga_colour}, {m_plot, m_x, m_y, m_col});
      end
      tests_run++;
      if ({level, full, empty, idle} !== {4'(exp_q.size()), exp_q.size() == DEPTH,
                                          exp_q.size() == 0, exp_q.size() == 0 && !m_plot}) begin
        tests_failed++;
        $display("FAIL rand_status[%0d]: got lvl=%0d f=%b e=%b i=%b expected lvl=%0d", c,
                 level, full, empty, idle, exp_q.size());
      end
      tests_run++;
      if ({overflow, clipped} !== {m_ovf, m_clip}) begin
        tests_failed++;
        $display("FAIL rand_flags[%0d]: got ovf/clip=%b expected %b", c, {overflow, clipped}, {m_ovf, m_clip});
      end
    end
    drive_idle();
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; plot_count = 0;
    test_reset();
    test_single();
    test_overflow();
    test_clip();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
